// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and opcode helpers for the ALU command issuer.
package alu_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_ROL  = 4'd0;
  localparam logic [OPC_W-1:0] OP_ROR  = 4'd1;
  localparam logic [OPC_W-1:0] OP_MAX  = 4'd2;
  localparam logic [OPC_W-1:0] OP_MIN  = 4'd3;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'd4;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'd5;
  localparam logic [OPC_W-1:0] OP_DIV  = 4'd6;
  localparam logic [OPC_W-1:0] OP_NOR  = 4'd7;
  localparam logic [OPC_W-1:0] OP_OR   = 4'd8;
  localparam logic [OPC_W-1:0] OP_LAST = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Legal opcode range is OP_ROL through OP_LAST.
  function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
    return (op <= OP_LAST);
  endfunction

  // Only arithmetic ops produce a meaningful carry.
  function automatic logic op_has_carry(input logic [OPC_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_issuer.sv
// Drives a combinational ALU from a valid/ready command stream, waits a
// programmable settle window, and returns the sampled result on a
// valid/ready response stream. One operation in flight at a time.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_W    = 5,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned SETTLE     = 1,
  parameter int unsigned DIV_SETTLE = 3
) (
  input  logic               clk,
  input  logic               rst,
  // command stream
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_opcode,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic [SHIFT_W-1:0] cmd_shift,
  input  logic [TAG_W-1:0]   cmd_tag,
  // ALU port
  output logic [3:0]         alu_opcode,
  output logic [WIDTH-1:0]   alu_input1,
  output logic [WIDTH-1:0]   alu_input2,
  output logic [SHIFT_W-1:0] alu_shiftValue,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carryFlag,
  // response stream
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_carry,
  output logic               rsp_zero,
  output logic               rsp_div0,
  output logic               rsp_illegal,
  output logic [TAG_W-1:0]   rsp_tag,
  // status
  output logic               busy,
  output logic [15:0]        op_count
);

  localparam int unsigned MAX_SETTLE = (SETTLE > DIV_SETTLE) ? SETTLE : DIV_SETTLE;
  localparam int unsigned CNT_W      = $clog2(MAX_SETTLE) + 1;
  localparam int unsigned OPCNT_W    = 16;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q, busy_d;
  logic [3:0]           alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0]     alu_in1_q, alu_in1_d;
  logic [WIDTH-1:0]     alu_in2_q, alu_in2_d;
  logic [SHIFT_W-1:0]   alu_shift_q, alu_shift_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]     rsp_result_q, rsp_result_d;
  logic                 rsp_carry_q, rsp_carry_d;
  logic                 rsp_zero_q, rsp_zero_d;
  logic                 rsp_div0_q, rsp_div0_d;
  logic                 rsp_illegal_q, rsp_illegal_d;
  logic [TAG_W-1:0]     rsp_tag_q, rsp_tag_d;
  logic [OPCNT_W-1:0]   op_count_q, op_count_d;

  // Next-state and next-output logic for the issue/settle/respond sequence.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_opcode_d  = alu_opcode_q;
    alu_in1_d     = alu_in1_q;
    alu_in2_d     = alu_in2_q;
    alu_shift_d   = alu_shift_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_carry_d   = rsp_carry_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_div0_d    = rsp_div0_q;
    rsp_illegal_d = rsp_illegal_q;
    rsp_tag_d     = rsp_tag_q;
    op_count_d    = op_count_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rsp_tag_d     = cmd_tag;
          rsp_div0_d    = 1'b0;
          rsp_illegal_d = 1'b0;
          if (!op_is_legal(cmd_opcode)) begin
            // Illegal ops bypass the ALU; response follows one beat later.
            state_d       = RESP;
            rsp_illegal_d = 1'b1;
            rsp_result_d  = '0;
            rsp_carry_d   = 1'b0;
            rsp_zero_d    = 1'b0;
          end else begin
            state_d      = WAIT;
            alu_opcode_d = cmd_opcode;
            alu_in1_d    = cmd_a;
            alu_in2_d    = cmd_b;
            alu_shift_d  = cmd_shift;
            rsp_div0_d   = (cmd_opcode == OP_DIV) && (cmd_b == '0);
            cnt_d        = (cmd_opcode == OP_DIV) ? CNT_W'(DIV_SETTLE) : CNT_W'(SETTLE);
          end
        end
      end

      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_result_d = alu_result;
          rsp_carry_d  = op_has_carry(alu_opcode_q) & alu_carryFlag;
          rsp_zero_d   = (alu_result == '0);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          op_count_d  = op_count_q + OPCNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset drops any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      alu_opcode_q  <= '0;
      alu_in1_q     <= '0;
      alu_in2_q     <= '0;
      alu_shift_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_carry_q   <= 1'b0;
      rsp_zero_q    <= 1'b0;
      rsp_div0_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_tag_q     <= '0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      alu_opcode_q  <= alu_opcode_d;
      alu_in1_q     <= alu_in1_d;
      alu_in2_q     <= alu_in2_d;
      alu_shift_q   <= alu_shift_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_carry_q   <= rsp_carry_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_div0_q    <= rsp_div0_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_tag_q     <= rsp_tag_d;
      op_count_q    <= op_count_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign alu_opcode     = alu_opcode_q;
  assign alu_input1     = alu_in1_q;
  assign alu_input2     = alu_in2_q;
  assign alu_shiftValue = alu_shift_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_result     = rsp_result_q;
  assign rsp_carry      = rsp_carry_q;
  assign rsp_zero       = rsp_zero_q;
  assign rsp_div0       = rsp_div0_q;
  assign rsp_illegal    = rsp_illegal_q;
  assign rsp_tag        = rsp_tag_q;
  assign op_count       = op_count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: behavioural ALU on the alu_* port, scoreboard of
// expected responses pushed at command accept and checked at handshake.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned SHIFT_W    = 5;
  localparam int unsigned TAG_W      = 4;
  localparam int unsigned SETTLE     = 1;
  localparam int unsigned DIV_SETTLE = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [3:0]         cmd_opcode;
  logic [WIDTH-1:0]   cmd_a, cmd_b;
  logic [SHIFT_W-1:0] cmd_shift;
  logic [TAG_W-1:0]   cmd_tag;
  logic [3:0]         alu_opcode;
  logic [WIDTH-1:0]   alu_input1, alu_input2, alu_result;
  logic [SHIFT_W-1:0] alu_shiftValue;
  logic               alu_carryFlag;
  logic               rsp_valid, rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_carry, rsp_zero, rsp_div0, rsp_illegal;
  logic [TAG_W-1:0]   rsp_tag;
  logic               busy;
  logic [15:0]        op_count;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        d0;
    logic        ill;
    logic [3:0]  tag;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_issuer #(
    .WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .TAG_W(TAG_W),
    .SETTLE(SETTLE), .DIV_SETTLE(DIV_SETTLE)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift), .cmd_tag(cmd_tag),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shiftValue(alu_shiftValue), .alu_result(alu_result), .alu_carryFlag(alu_carryFlag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_div0(rsp_div0),
    .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag),
    .busy(busy), .op_count(op_count)
  );

  // Behavioural ALU; carry is deliberately 1 for non-arithmetic ops.
  logic [63:0] rot_l, rot_r;
  logic [32:0] sum, dif;
  always_comb begin
    rot_l         = {alu_input1, alu_input1} << alu_shiftValue;
    rot_r         = {alu_input1, alu_input1} >> alu_shiftValue;
    sum           = {1'b0, alu_input1} + {1'b0, alu_input2};
    dif           = {1'b0, alu_input1} - {1'b0, alu_input2};
    alu_carryFlag = 1'b1;
    alu_result    = '0;
    case (alu_opcode)
      OP_ROL: alu_result = rot_l[63:32];
      OP_ROR: alu_result = rot_r[31:0];
      OP_MAX: alu_result = (alu_input1 > alu_input2) ? alu_input1 : alu_input2;
      OP_MIN: alu_result = (alu_input1 < alu_input2) ? alu_input1 : alu_input2;
      OP_ADD: begin alu_result = sum[31:0]; alu_carryFlag = sum[32]; end
      OP_SUB: begin alu_result = dif[31:0]; alu_carryFlag = dif[32]; end
      OP_DIV: alu_result = (alu_input2 == '0) ? '0 : alu_input1 / alu_input2;
      OP_NOR: alu_result = ~(alu_input1 | alu_input2);
      OP_OR:  alu_result = alu_input1 | alu_input2;
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one command, waiting for cmd_ready; push its expected response.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic [3:0] tag, input logic [31:0] er,
                      input logic ec, input logic ed0, input logic eill, input int lat);
    exp_t e;
    int   n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shift = sh; cmd_tag = tag;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      chk("cmd_ready_timeout", 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b0;
      return;
    end
    e.res = er; e.c = ec; e.z = (er == 32'd0) && !eill; e.d0 = ed0; e.ill = eill;
    e.tag = tag; e.lat = lat; e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Response monitor: latency on first valid beat, payload on handshake.
  initial begin
    bit seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !rsp_valid) begin
        seen = 1'b0;
      end else if (sb.size() == 0) begin
        if (!seen) chk("spurious_rsp", 64'(rsp_valid), 64'(0));
        seen = 1'b1;
      end else begin
        if (!seen) begin
          chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          seen = 1'b1;
        end
        if (rsp_ready) begin
          chk("rsp_result",  64'(rsp_result),  64'(sb[0].res));
          chk("rsp_carry",   64'(rsp_carry),   64'(sb[0].c));
          chk("rsp_zero",    64'(rsp_zero),    64'(sb[0].z));
          chk("rsp_div0",    64'(rsp_div0),    64'(sb[0].d0));
          chk("rsp_illegal", 64'(rsp_illegal), 64'(sb[0].ill));
          chk("rsp_tag",     64'(rsp_tag),     64'(sb[0].tag));
          void'(sb.pop_front());
          exp_cnt++;
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [31:0] ra, rb;
    logic [32:0] rs;
    int          n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
    cmd_shift = '0; cmd_tag = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready",  64'(cmd_ready),  64'(1));
    chk("rst_rsp_valid",  64'(rsp_valid),  64'(0));
    chk("rst_busy",       64'(busy),       64'(0));
    chk("rst_op_count",   64'(op_count),   64'(0));
    chk("rst_alu_opcode", 64'(alu_opcode), 64'(0));
    chk("rst_alu_input1", 64'(alu_input1), 64'(0));
    rst = 1'b0;

    // Directed vectors.
    send(OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0, 4'd1, 32'd0, 1'b1, 1'b0, 1'b0, SETTLE);
    chk("busy_in_flight", 64'(busy), 64'(1));
    chk("cmd_ready_in_flight", 64'(cmd_ready), 64'(0));
    send(OP_DIV, 32'd10, 32'd0, 5'd0, 4'd2, 32'd0, 1'b0, 1'b1, 1'b0, DIV_SETTLE);
    send(OP_DIV, 32'd100, 32'd7, 5'd0, 4'd3, 32'd14, 1'b0, 1'b0, 1'b0, DIV_SETTLE);
    send(OP_ROL, 32'h8000_0001, 32'd0, 5'd1, 4'd4, 32'h0000_0003, 1'b0, 1'b0, 1'b0, SETTLE);
    send(OP_ROR, 32'h8000_0001, 32'd0, 5'd4, 4'd6, 32'h1800_0000, 1'b0, 1'b0, 1'b0, SETTLE);
    send(4'd12, 32'h1234_5678, 32'h9, 5'd3, 4'd5, 32'd0, 1'b0, 1'b0, 1'b1, 1);
    chk("illegal_keeps_opcode", 64'(alu_opcode), 64'(OP_ROR));
    chk("illegal_keeps_input1", 64'(alu_input1), 64'(32'h8000_0001));
    send(OP_MAX, 32'd5, 32'h8000_0000, 5'd0, 4'd7, 32'h8000_0000, 1'b0, 1'b0, 1'b0, SETTLE);
    send(OP_MIN, 32'd5, 32'd9, 5'd0, 4'd8, 32'd5, 1'b0, 1'b0, 1'b0, SETTLE);
    send(OP_SUB, 32'd3, 32'd5, 5'd0, 4'd9, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, SETTLE);
    send(OP_SUB, 32'd5, 32'd5, 5'd0, 4'd10, 32'd0, 1'b0, 1'b0, 1'b0, SETTLE);
    send(OP_NOR, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 5'd0, 4'd11, 32'd0, 1'b0, 1'b0, 1'b0, SETTLE);
    send(OP_OR, 32'h0000_1200, 32'h0000_0034, 5'd0, 4'd12, 32'h0000_1234, 1'b0, 1'b0, 1'b0, SETTLE);
    send(4'd15, 32'd0, 32'd0, 5'd0, 4'd13, 32'd0, 1'b0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom;
      rs = {1'b0, ra} + {1'b0, rb};
      send(OP_ADD, ra, rb, 5'd0, 4'(i), rs[31:0], rs[32], 1'b0, 1'b0, SETTLE);
    end
    drain();
    chk("op_count_after_directed", 64'(op_count), 64'(exp_cnt));

    // Backpressure: response must hold for 5 cycles.
    rsp_ready = 1'b0;
    send(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 4'd9, 32'h8000_0000, 1'b0, 1'b0, 1'b0, SETTLE);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_valid", 64'(rsp_valid), 64'(1));
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", 64'(rsp_valid),  64'(1));
      chk("bp_result",    64'(rsp_result), 64'(32'h8000_0000));
      chk("bp_tag",       64'(rsp_tag),    64'(9));
      chk("bp_cmd_ready", 64'(cmd_ready),  64'(0));
      chk("bp_op_count",  64'(op_count),   64'(exp_cnt));
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain();
    chk("op_count_after_bp", 64'(op_count), 64'(exp_cnt));

    // Reset while an op is settling.
    send(OP_DIV, 32'd50, 32'd5, 5'd0, 4'd3, 32'd10, 1'b0, 1'b0, 1'b0, DIV_SETTLE);
    rst = 1'b1;
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_op_count",  64'(op_count),  64'(0));
    chk("mid_rst_busy",      64'(busy),      64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_no_rsp", 64'(rsp_valid), 64'(0));

    send(OP_ADD, 32'd2, 32'd3, 5'd0, 4'd14, 32'd5, 1'b0, 1'b0, 1'b0, SETTLE);
    drain();
    chk("op_count_final", 64'(op_count), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
